mem_port_arbiter: RTL and testbench

Shares port A of the dual-port data memory between the multicycle CPU control path and a second requester (the I/O / DMA side), so that both can issue single-word loads and stores without contention. The arbiter runs a small FSM that picks one request at a time (round-robin on collision) and drives the memory port from latched request registers. It returns a one-cycle completion pulse with read data to the winner. It sits between controlFSM's memory-access states and the altsyncram port A (`wren_a`, address, data, q).

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares memory port A between the CPU control path and the
// I/O / DMA requester. One access at a time, round-robin on collision, with
// the selected request latched and replayed onto the memory port. A write
// completes in two cycles and a read in three, counted from the request edge.
module mem_port_arbiter #(
    parameter int WIDTH    = 16,
    parameter int ADDRBITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDRBITS-1:0] cpu_addr,
    input  logic [WIDTH-1:0]    cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_done,
    output logic [WIDTH-1:0]    cpu_rdata,
    input  logic                io_req,
    input  logic                io_we,
    input  logic [ADDRBITS-1:0] io_addr,
    input  logic [WIDTH-1:0]    io_wdata,
    output logic                io_gnt,
    output logic                io_done,
    output logic [WIDTH-1:0]    io_rdata,
    output logic [ADDRBITS-1:0] mem_addr_a,
    output logic [WIDTH-1:0]    mem_data_a,
    output logic                wren_a,
    input  logic [WIDTH-1:0]    mem_q_a,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                any_req_s;
    logic                win_io_s;
    logic                last_io_r;
    logic                sel_io_r;
    logic                we_r;
    logic                cpu_gnt_r;
    logic                io_gnt_r;
    logic                cpu_done_r;
    logic                io_done_r;
    logic [WIDTH-1:0]    cpu_rdata_r;
    logic [WIDTH-1:0]    io_rdata_r;
    logic [ADDRBITS-1:0] addr_r;
    logic [WIDTH-1:0]    data_r;

    // Arbitration: a lone request wins; on collision the side not served last wins.
    always_comb begin
        any_req_s = cpu_req | io_req;
        win_io_s  = io_req & (~cpu_req | ~last_io_r);
    end

    // State register; reset drops any in-flight access immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: IDLE -> ACC on any request, ACC -> IDLE (write) or RD (read).
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_ACC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (we_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RD;
                end
            end
            ST_RD:   state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request latch, one-cycle grant/done pulses and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_io_r   <= 1'b1;
            sel_io_r    <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {ADDRBITS{1'b0}};
            data_r      <= {WIDTH{1'b0}};
            cpu_gnt_r   <= 1'b0;
            io_gnt_r    <= 1'b0;
            cpu_done_r  <= 1'b0;
            io_done_r   <= 1'b0;
            cpu_rdata_r <= {WIDTH{1'b0}};
            io_rdata_r  <= {WIDTH{1'b0}};
        end else begin
            cpu_gnt_r  <= 1'b0;
            io_gnt_r   <= 1'b0;
            cpu_done_r <= 1'b0;
            io_done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        sel_io_r  <= win_io_s;
                        last_io_r <= win_io_s;
                        cpu_gnt_r <= ~win_io_s;
                        io_gnt_r  <= win_io_s;
                        if (win_io_s) begin
                            addr_r <= io_addr;
                            data_r <= io_wdata;
                            we_r   <= io_we;
                        end else begin
                            addr_r <= cpu_addr;
                            data_r <= cpu_wdata;
                            we_r   <= cpu_we;
                        end
                    end
                end
                ST_ACC: begin
                    if (we_r) begin
                        cpu_done_r <= ~sel_io_r;
                        io_done_r  <= sel_io_r;
                    end
                end
                ST_RD: begin
                    cpu_done_r <= ~sel_io_r;
                    io_done_r  <= sel_io_r;
                    if (sel_io_r) begin
                        io_rdata_r <= mem_q_a;
                    end else begin
                        cpu_rdata_r <= mem_q_a;
                    end
                end
                default: begin
                    we_r <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt    = cpu_gnt_r;
    assign io_gnt     = io_gnt_r;
    assign cpu_done   = cpu_done_r;
    assign io_done    = io_done_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign io_rdata   = io_rdata_r;
    assign mem_addr_a = addr_r;
    assign mem_data_a = data_r;
    // Write strobe and busy decode straight from state so reset kills them at once.
    assign wren_a     = (state_r == ST_ACC) & we_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_done;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        io_req, io_we, io_gnt, io_done;
    logic [15:0] io_addr, io_wdata, io_rdata;
    logic [15:0] mem_addr_a, mem_data_a, mem_q_a;
    logic        wren_a, busy;
    logic        mem_init;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(16), .ADDRBITS(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_done(io_done), .io_rdata(io_rdata),
        .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .wren_a(wren_a),
        .mem_q_a(mem_q_a), .busy(busy)
    );

    // Synchronous-read memory model (low 8 address bits used).
    logic [15:0] mem_m [0:255];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_m[i] <= 16'h0000;
        end else if (wren_a) begin
            mem_m[mem_addr_a[7:0]] <= mem_data_a;
        end
        mem_q_a <= mem_m[mem_addr_a[7:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model state: index 0 = CPU, 1 = I/O.
    string       nm [2] = '{"cpu", "io"};
    bit          pend [2], hold [2], stream [2], outst [2], out_we [2], req_we [2];
    logic [15:0] req_addr [2], req_wdata [2], out_addr [2], out_wdata [2], exp_rd [2];
    int          done_at [2], wait_cyc [2], foreign [2];
    logic [15:0] ref_mem [0:255];
    logic [15:0] last_addr, last_data;
    int          last_w, cyc;
    bit          rnd_en;
    int          glog_side [$];
    int          glog_cyc [$];

    task automatic apply_reqs();
        cpu_req = pend[0]; cpu_we = req_we[0]; cpu_addr = req_addr[0]; cpu_wdata = req_wdata[0];
        io_req  = pend[1]; io_we  = req_we[1]; io_addr  = req_addr[1]; io_wdata  = req_wdata[1];
    endtask

    task automatic issue(input int s, input bit we, input logic [15:0] addr, input logic [15:0] data);
        pend[s] = 1'b1; req_we[s] = we; req_addr[s] = addr; req_wdata[s] = data; wait_cyc[s] = 0;
        apply_reqs();
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            pend[s] = 1'b0; hold[s] = 1'b0; stream[s] = 1'b0; outst[s] = 1'b0;
            req_we[s] = 1'b0; req_addr[s] = 16'h0; req_wdata[s] = 16'h0;
            exp_rd[s] = 16'h0; foreign[s] = 0; wait_cyc[s] = 0;
        end
        last_w = 1; last_addr = 16'h0; last_data = 16'h0;
        apply_reqs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: observe at the falling edge, check against the model, drive new requests.
    task automatic step();
        logic [1:0] samp, gnt_v, done_v;
        bit         exp_wren, exp_busy, granted [2];
        @(negedge clk);
        cyc++;
        samp   = {io_req, cpu_req};
        gnt_v  = {io_gnt, cpu_gnt};
        done_v = {io_done, cpu_done};
        exp_wren = 1'b0;
        for (int s = 0; s < 2; s++) begin
            bit exp_d;
            exp_d = outst[s] && (cyc == done_at[s]);
            check_val($sformatf("%s_done", nm[s]), done_v[s], exp_d);
            if (exp_d) begin
                if (out_we[s]) ref_mem[out_addr[s][7:0]] = out_wdata[s];
                else           exp_rd[s] = ref_mem[out_addr[s][7:0]];
                outst[s] = 1'b0;
                hold[s]  = 1'b0;
            end
        end
        check_val("dual_gnt", gnt_v == 2'b11, 1'b0);
        for (int s = 0; s < 2; s++) begin
            granted[s] = gnt_v[s];
            if (gnt_v[s]) begin
                check_val($sformatf("%s_gnt_spur", nm[s]), samp[s], 1'b1);
                check_val("gnt_overlap", outst[0] | outst[1], 1'b0);
                check_val($sformatf("%s_gnt_addr", nm[s]), mem_addr_a, req_addr[s]);
                check_val($sformatf("%s_gnt_data", nm[s]), mem_data_a, req_wdata[s]);
                if (samp == 2'b11) check_val("rr_order", s, 1 - last_w);
                check_val($sformatf("%s_starve", nm[s]), foreign[s] > 1, 1'b0);
                last_w = s;
                foreign[s] = 0;
                if (samp[1-s]) foreign[1-s]++;
                outst[s] = 1'b1; out_we[s] = req_we[s];
                out_addr[s] = req_addr[s]; out_wdata[s] = req_wdata[s];
                done_at[s] = cyc + (req_we[s] ? 1 : 2);
                last_addr = req_addr[s]; last_data = req_wdata[s];
                exp_wren = req_we[s];
                glog_side.push_back(s); glog_cyc.push_back(cyc);
                wait_cyc[s] = 0;
                if (!hold[s]) pend[s] = 1'b0;
            end
        end
        exp_busy = (outst[0] && cyc < done_at[0]) || (outst[1] && cyc < done_at[1]);
        check_val("wren_a", wren_a, exp_wren);
        check_val("busy", busy, exp_busy);
        check_val("addr_hold", mem_addr_a, last_addr);
        check_val("data_hold", mem_data_a, last_data);
        check_val("cpu_rdata", cpu_rdata, exp_rd[0]);
        check_val("io_rdata", io_rdata, exp_rd[1]);
        for (int s = 0; s < 2; s++) begin
            if (pend[s]) begin
                wait_cyc[s]++;
                if (wait_cyc[s] > 12) begin
                    check_val($sformatf("%s_timeout", nm[s]), 1'b0, 1'b1);
                    pend[s] = 1'b0;
                end
            end
            if (!pend[s] && !granted[s]) begin
                if (stream[s])
                    issue(s, 1'b1, 16'h0040 + 16'($urandom_range(0, 15)), 16'($urandom));
                else if (rnd_en && $urandom_range(0, 2) == 0)
                    issue(s, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
            end
        end
        apply_reqs();
    endtask

    task automatic drain(input int n);
        int guard;
        repeat (n) step();
        guard = 0;
        while ((pend[0] | pend[1] | outst[0] | outst[1]) && guard < 50) begin
            step();
            guard++;
        end
        check_val("drain_idle", pend[0] | pend[1] | outst[0] | outst[1], 1'b0);
    endtask

    initial begin
        reset = 1'b0; mem_init = 1'b1; cyc = 0; rnd_en = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("rst_cpu_gnt", cpu_gnt, 1'b0);
        check_val("rst_io_gnt", io_gnt, 1'b0);
        check_val("rst_cpu_done", cpu_done, 1'b0);
        check_val("rst_io_done", io_done, 1'b0);
        check_val("rst_wren", wren_a, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_addr", mem_addr_a, 16'h0000);
        check_val("rst_data", mem_data_a, 16'h0000);
        check_val("rst_cpu_rdata", cpu_rdata, 16'h0000);
        check_val("rst_io_rdata", io_rdata, 16'h0000);
        mem_init = 1'b0;
        reset = 1'b1;

        // CPU write alone: gnt with wren in cycle 1, done in cycle 2.
        issue(0, 1'b1, 16'h0010, 16'hBEEF);
        step();
        check_val("w_gnt", cpu_gnt, 1'b1);
        check_val("w_wren", wren_a, 1'b1);
        step();
        check_val("w_done", cpu_done, 1'b1);
        check_val("w_io_quiet", {io_gnt, io_done, io_rdata}, 18'h0);
        drain(3);

        // CPU read back: done and data in cycle 3.
        issue(0, 1'b0, 16'h0010, 16'h0000);
        repeat (3) step();
        check_val("r_done", cpu_done, 1'b1);
        check_val("r_rdata", cpu_rdata, 16'hBEEF);
        drain(3);

        // Collisions after reset; the CPU re-requests through its done.
        do_reset();
        glog_side.delete(); glog_cyc.delete();
        hold[0] = 1'b1;
        issue(0, 1'b1, 16'h0001, 16'h1111);
        issue(1, 1'b1, 16'h0002, 16'h2222);
        drain(10);
        check_val("col_n", glog_side.size(), 3);
        check_val("col_first", glog_side[0], 0);
        check_val("col_second", glog_side[1], 1);
        check_val("col_gap", glog_cyc[1] - glog_cyc[0], 2);
        check_val("col_third", glog_side[2], 0);
        issue(0, 1'b1, 16'h0003, 16'h3333);
        issue(1, 1'b1, 16'h0004, 16'h4444);
        drain(6);
        check_val("col2_first", glog_side[3], 1);

        // I/O read under continuous CPU write traffic.
        stream[0] = 1'b1;
        repeat (3) step();
        issue(1, 1'b0, 16'h0002, 16'h0000);
        repeat (12) step();
        stream[0] = 1'b0;
        drain(4);
        check_val("io_rd_2222", io_rdata, 16'h2222);

        // Reset in the ACC cycle of a write: no write, no done.
        issue(0, 1'b1, 16'h0030, 16'h5555);
        step();
        check_val("ra_wren_pre", wren_a, 1'b1);
        #1 reset = 1'b0;
        model_reset();
        #1;
        check_val("ra_wren", wren_a, 1'b0);
        check_val("ra_busy", busy, 1'b0);
        check_val("ra_gnt", cpu_gnt, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        drain(4);
        check_val("ra_mem", mem_m[8'h30], 16'h0000);

        // Holding req through done yields exactly one extra access.
        glog_side.delete(); glog_cyc.delete();
        hold[0] = 1'b1;
        issue(0, 1'b1, 16'h0050, 16'h1234);
        drain(10);
        check_val("hold_n", glog_side.size(), 2);
        check_val("hold_gap", glog_cyc[1] - glog_cyc[0], 2);

        // Randomized mixed traffic.
        rnd_en = 1'b1;
        repeat (1500) step();
        rnd_en = 1'b0;
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
